// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - widths, FSM states and operand-pair type shared by mult_sequencer and its FIFO
package mult_seq_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mult_seq_fifo.sv
// rtl/mult_seq_fifo.sv - operand-pair FIFO; full/empty come from registered count so push never relies on a same-cycle pop
module mult_seq_fifo
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push_i,
  input  op_pair_t               push_data_i,
  input  logic                   pop_i,
  output op_pair_t               head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  op_pair_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - feeds buffered operand pairs to a serial-input multiplier and returns products
// Optional WAIT abort with sticky err_o when MULT_SEQ_TIMEOUT_EN is defined.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [OP_W-1:0]   op_a_i,
  input  logic [OP_W-1:0]   op_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [PROD_W-1:0] res_data_o,
  output logic              mul_start_o,
  output logic [OP_W-1:0]   mul_data_o,
  input  logic              mul_done_i,
  input  logic [PROD_W-1:0] mul_prod_i,
  output logic              busy_o,
  output logic              err_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mult_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e                      state_q, state_d;
  logic [OP_W-1:0]             b_q, b_d;
  logic [PROD_W-1:0]           res_data_q, res_data_d;
  op_pair_t                    push_pair, head;
  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        wait_expired;

  assign push_pair = '{a: op_a_i, b: op_b_i};

  mult_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (op_valid_i),
    .push_data_i (push_pair),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign op_ready_o = !fifo_full;
  assign res_data_o = res_data_q;
  assign busy_o     = (state_q != IDLE) || (fifo_count != '0);

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  // Counter restarts on every WAIT entry; a done in the final cycle still wins over the abort.
  always_comb begin
    wait_cnt_d   = '0;
    err_d        = err_q;
    wait_expired = 1'b0;
    if (state_q == WAIT && !mul_done_i) begin
      if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        wait_expired = 1'b1;
        err_d        = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign wait_expired = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;
    mul_start_o = 1'b0;
    mul_data_o  = '0;
    res_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = SEND_A;
      end
      SEND_A: begin
        mul_start_o = 1'b1;
        mul_data_o  = head.a;
        b_d         = head.b;
        fifo_pop    = 1'b1;
        state_d     = SEND_B;
      end
      SEND_B: begin
        mul_data_o = b_q;
        state_d    = WAIT;
      end
      WAIT: begin
        mul_data_o = b_q;
        if (mul_done_i) begin
          res_data_d = mul_prod_i;
          state_d    = RESULT;
        end else if (wait_expired) begin
          state_d = IDLE;
        end
      end
      RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      b_q        <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
    end
  end

endmodule
